// File: rtl/ama_riscv_lsu_pkg.sv
// Shared types for the ama-riscv load/store unit: memory access types,
// LSU FSM states, address-region codes and the port word-address width.
package ama_riscv_lsu_pkg;

   localparam int CORE_ADDR_BUS_W = 14;

   // Region codes found in byte-address bits [17:16]
   localparam logic [1:0] DMEM_RANGE = 2'b00;
   localparam logic [1:0] MMIO_RANGE = 2'b01;

   // Access type, encoded like the RISC-V load/store funct3 field
   typedef enum logic [2:0] {
      DMEM_DTYPE_BYTE  = 3'b000,
      DMEM_DTYPE_HALF  = 3'b001,
      DMEM_DTYPE_WORD  = 3'b010,
      DMEM_DTYPE_UBYTE = 3'b100,
      DMEM_DTYPE_UHALF = 3'b101
   } dmem_dtype_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_RD = 2'd2,
      DONE    = 2'd3
   } lsu_state_t;

   // 3'b011, 3'b110 and 3'b111 are not valid access types
   function automatic logic dtype_legal(input logic [2:0] dt);
      logic ok;
      ok = 1'b0;
      case (dt)
         DMEM_DTYPE_BYTE, DMEM_DTYPE_HALF, DMEM_DTYPE_WORD,
         DMEM_DTYPE_UBYTE, DMEM_DTYPE_UHALF: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/ama_riscv_lsu_align.sv
// Combinational lane logic for the LSU: store-data replication plus byte
// strobes, and load-lane extraction with sign/zero extension. The offset
// given here is already the effective (possibly forced-aligned) offset.
module ama_riscv_lsu_align
   import ama_riscv_lsu_pkg::*;
(
   input  logic [2:0]  i_dtype,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_wstrb,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata
);

   logic [31:0] w_lane;

   // Store strobes/data and load extension selected by access type
   always_comb begin
      o_wstrb = 4'b0000;
      o_wdata = i_wdata;
      w_lane  = i_rdata >> {i_off, 3'b000};
      o_rdata = w_lane;
      case (i_dtype)
         DMEM_DTYPE_BYTE: begin
            o_wstrb = 4'b0001 << i_off;
            o_wdata = {4{i_wdata[7:0]}};
            o_rdata = {{24{w_lane[7]}}, w_lane[7:0]};
         end
         DMEM_DTYPE_UBYTE: begin
            o_wstrb = 4'b0001 << i_off;
            o_wdata = {4{i_wdata[7:0]}};
            o_rdata = {24'd0, w_lane[7:0]};
         end
         DMEM_DTYPE_HALF: begin
            o_wstrb = 4'b0011 << i_off;
            o_wdata = {2{i_wdata[15:0]}};
            o_rdata = {{16{w_lane[15]}}, w_lane[15:0]};
         end
         DMEM_DTYPE_UHALF: begin
            o_wstrb = 4'b0011 << i_off;
            o_wdata = {2{i_wdata[15:0]}};
            o_rdata = {16'd0, w_lane[15:0]};
         end
         DMEM_DTYPE_WORD: begin
            o_wstrb = 4'b1111;
            o_wdata = i_wdata;
            o_rdata = w_lane;
         end
         default: begin
            o_wstrb = 4'b0000;
            o_wdata = i_wdata;
            o_rdata = w_lane;
         end
      endcase
   end

endmodule

// File: rtl/ama_riscv_lsu.sv
// MEM-stage load/store unit: one outstanding access, valid/ready port to
// DMEM/MMIO, single-cycle response pulse to writeback.
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned
// half/word accesses fault; otherwise the offset is forced aligned.
module ama_riscv_lsu
   import ama_riscv_lsu_pkg::*;
#(
   parameter int AW     = 32,
   parameter int MEM_AW = CORE_ADDR_BUS_W
)(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_we,
   input  logic [2:0]        i_req_dtype,
   input  logic [AW-1:0]     i_req_addr,
   input  logic [31:0]       i_req_wdata,
   output logic              o_rsp_valid,
   output logic [31:0]       o_rsp_data,
   output logic              o_rsp_fault,
   output logic              o_mem_req_valid,
   input  logic              i_mem_req_ready,
   output logic              o_mem_req_we,
   output logic              o_mem_req_mmio,
   output logic [MEM_AW-1:0] o_mem_req_addr,
   output logic [31:0]       o_mem_req_wdata,
   output logic [3:0]        o_mem_req_wstrb,
   input  logic              i_mem_rsp_valid,
   input  logic [31:0]       i_mem_rsp_rdata
);

   lsu_state_t          r_state, w_state_nxt;
   logic                r_we, r_mmio, r_fault;
   logic [2:0]          r_dtype;
   logic [1:0]          r_off;
   logic [MEM_AW-1:0]   r_addr;
   logic [31:0]         r_wdata, r_rsp_data;

   logic                w_accept, w_fault, w_misalign, w_region_bad;
   logic [1:0]          w_region, w_off, w_off_eff;
   logic [3:0]          w_wstrb;
   logic [31:0]         w_wdata_al, w_rdata_ext;
   logic                w_unused_addr;

   assign w_unused_addr = ^i_req_addr[AW-1:18];
   assign w_accept      = i_req_valid && (r_state == IDLE);
   assign w_region      = i_req_addr[17:16];
   assign w_off         = i_req_addr[1:0];

   // Request decode: region, type legality, misalignment and effective offset
   always_comb begin
      w_region_bad = !((w_region == DMEM_RANGE) || (w_region == MMIO_RANGE));
      w_misalign   = 1'b0;
      w_off_eff    = w_off;
      case (i_req_dtype)
         DMEM_DTYPE_HALF, DMEM_DTYPE_UHALF: begin
`ifdef LSU_MISALIGN_TRAP_EN
            w_misalign = w_off[0];
`else
            w_off_eff  = {w_off[1], 1'b0};
`endif
         end
         DMEM_DTYPE_WORD: begin
`ifdef LSU_MISALIGN_TRAP_EN
            w_misalign = |w_off;
`else
            w_off_eff  = 2'b00;
`endif
         end
         default: w_off_eff = w_off;
      endcase
      w_fault = w_region_bad || !dtype_legal(i_req_dtype) || w_misalign;
   end

   ama_riscv_lsu_align u_align (
      .i_dtype (r_dtype),
      .i_off   (r_off),
      .i_wdata (r_wdata),
      .i_rdata (i_mem_rsp_rdata),
      .o_wstrb (w_wstrb),
      .o_wdata (w_wdata_al),
      .o_rdata (w_rdata_ext)
   );

   // State register; reset abandons any access in flight
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next state and port outputs, all ports quiet outside their state
   always_comb begin
      w_state_nxt     = r_state;
      o_req_ready     = 1'b0;
      o_rsp_valid     = 1'b0;
      o_rsp_data      = 32'd0;
      o_rsp_fault     = 1'b0;
      o_mem_req_valid = 1'b0;
      o_mem_req_we    = 1'b0;
      o_mem_req_mmio  = 1'b0;
      o_mem_req_addr  = '0;
      o_mem_req_wdata = 32'd0;
      o_mem_req_wstrb = 4'b0000;
      case (r_state)
         IDLE: begin
            o_req_ready = 1'b1;
            if (i_req_valid) w_state_nxt = w_fault ? DONE : ISSUE;
         end
         ISSUE: begin
            o_mem_req_valid = 1'b1;
            o_mem_req_we    = r_we;
            o_mem_req_mmio  = r_mmio;
            o_mem_req_addr  = r_addr;
            o_mem_req_wdata = r_we ? w_wdata_al : 32'd0;
            o_mem_req_wstrb = r_we ? w_wstrb : 4'b0000;
            if (i_mem_req_ready) w_state_nxt = r_we ? DONE : WAIT_RD;
         end
         WAIT_RD: begin
            if (i_mem_rsp_valid) w_state_nxt = DONE;
         end
         DONE: begin
            o_rsp_valid = 1'b1;
            o_rsp_data  = r_rsp_data;
            o_rsp_fault = r_fault;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Request capture on accept and load-data capture in WAIT_RD
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_we       <= 1'b0;
         r_mmio     <= 1'b0;
         r_fault    <= 1'b0;
         r_dtype    <= 3'd0;
         r_off      <= 2'd0;
         r_addr     <= '0;
         r_wdata    <= 32'd0;
         r_rsp_data <= 32'd0;
      end else begin
         if (w_accept) begin
            r_we       <= i_req_we;
            r_mmio     <= (w_region == MMIO_RANGE);
            r_fault    <= w_fault;
            r_dtype    <= i_req_dtype;
            r_off      <= w_off_eff;
            r_addr     <= i_req_addr[MEM_AW+1:2];
            r_wdata    <= i_req_wdata;
            r_rsp_data <= 32'd0;
         end
         if ((r_state == WAIT_RD) && i_mem_rsp_valid) r_rsp_data <= w_rdata_ext;
      end
   end

endmodule

// File: doc/ama_riscv_lsu.md
# ama_riscv_lsu

Load/store unit for the MEM stage of the ama-riscv core. It accepts one load or store per transaction from EXE, aligns store data and generates byte strobes, and drives the DMEM/MMIO port with a valid/ready handshake. It then sign- or zero-extends the returned load data and hands a single-cycle response to writeback. At most one memory access is outstanding; the core stalls while `req_ready` is low.

## Interface
- `AW`, 32: core byte-address width.
- `MEM_AW`, `CORE_ADDR_BUS_W` (14): word-address width on the memory port.
- `clk` in 1: core clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: EXE presents an access.
- `req_ready` out 1: LSU can accept an access; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_dtype` in 3: access type, `dmem_dtype_t`.
- `req_addr` in AW: byte address.
- `req_wdata` in 32: store data, LSB-justified.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_data` out 32: extended load data; 0 for stores and faults.
- `rsp_fault` out 1: access faulted; no memory access was made.
- `mem_req_valid` out 1: memory request valid.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_req_we` out 1: write enable.
- `mem_req_mmio` out 1: target is the MMIO range.
- `mem_req_addr` out MEM_AW: word address, `req_addr[MEM_AW+1:2]`.
- `mem_req_wdata` out 32: lane-replicated store data.
- `mem_req_wstrb` out 4: byte strobes; 0 for loads.
- `mem_rsp_valid` in 1: read data valid.
- `mem_rsp_rdata` in 32: read word.

## Operation
- FSM states and transitions:
  - IDLE: on `req_valid`, register the request. A fault goes to DONE; anything else goes to ISSUE.
  - ISSUE: hold `mem_req_valid`=1. On `mem_req_ready`, a store goes to DONE and a load goes to WAIT_RD.
  - WAIT_RD: on `mem_rsp_valid`, capture the extended data and go to DONE.
  - DONE: `rsp_valid`=1 for exactly one cycle, then go to IDLE.
- Region decode on `req_addr[17:16]`: `DMEM_RANGE` (2'b00) gives `mmio`=0; `MMIO_RANGE` (2'b01) gives `mmio`=1; any other value faults.
- Illegal `dtype` values (3'b011, 3'b110, 3'b111) fault.
- Byte offset is `off = req_addr[1:0]`.
- Store strobes and data:
  - BYTE: `wstrb = 4'b0001<<off`, data `{4{wdata[7:0]}}`.
  - HALF: `wstrb = 4'b0011<<off`, data `{2{wdata[15:0]}}`.
  - WORD: `wstrb = 4'b1111`, data unchanged.
- Load extraction: `lane = rdata >> (8*off)`.
  - BYTE / HALF: sign-extend bit 7 / bit 15.
  - UBYTE / UHALF: zero-extend.
  - WORD: pass through.
- Request fields stay stable while `mem_req_valid` is high and not yet accepted.
- `mem_rsp_valid` is ignored in every state except WAIT_RD.

## Timing
- Reset values:
  - All outputs 0 except `req_ready`=1; state is IDLE.
  - Asserting `rst_n` mid-transaction abandons the access. A late `mem_rsp_valid` after reset is ignored.
- Accept happens at cycle T (`req_valid & req_ready`). `mem_req_valid` rises at T+1.
- Store latency with zero-wait memory: handshake at T+1, `rsp_valid` at T+2.
- Load latency with zero-wait memory: handshake at T+1, `mem_rsp_valid` at T+2, `rsp_valid` at T+3.
- Fault: `rsp_valid` and `rsp_fault` at T+1; `mem_req_valid` never asserts.
- `req_ready` is low from T+1 until the cycle after DONE. Back-to-back accesses are therefore at least 3 cycles apart (store) or 4 cycles apart (load).
- Memory backpressure (`mem_req_ready` low) and read latency extend ISSUE and WAIT_RD without bound.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - HALF/UHALF with `off[0]`=1 faults.
  - WORD with `off`≠0 faults.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - No misalignment faults.
  - The effective offset is forced aligned: `off[0]` is cleared for halves, and `off` is 0 for words.

## Structure
- Shared defines: `dmem_dtype_t` (existing) plus a new `lsu_state_t` enum (IDLE, ISSUE, WAIT_RD, DONE) in the core defines.
- Sub-module `ama_riscv_lsu_align`: combinational store-lane alignment and strobe generation, and load-lane extraction and extension. The FSM and registers stay in `ama_riscv_lsu`.

## Test plan
- SB: addr 0x0000_0003, wdata 0x0000_00A5 → `wstrb` 4'b1000, `wdata` 0xA5A5_A5A5, `mem_req_addr` 0, `rsp_valid` at T+2.
- LB: addr 0x0000_0002 with rdata 0x0080_0000 → `rsp_data` 0xFFFF_FF80. LBU at the same address returns 0x0000_0080.
- LH at addr 0x0001_0006 with `mem_req_ready` low for 3 cycles, then rdata 0x8001_0000 → `mem_req_mmio`=1, request held stable, `rsp_data` 0xFFFF_8001 at T+6.
- SW to addr 0x0002_0000 → `rsp_fault`=1 at T+1, `mem_req_valid` never asserted. `req_dtype` 3'b111 at a legal address gives the same result.
- LW at addr 0x0000_0002:
  - With `LSU_MISALIGN_TRAP_EN`: fault at T+1.
  - Without it: `mem_req_addr` 0, `rsp_data` equals the full rdata.
- Load in WAIT_RD, `rst_n` pulsed low, then `mem_rsp_valid` arrives → no `rsp_valid`, `req_ready`=1, outputs 0.
